// File: rtl/hclk_gen.sv
//----------------------------------------------------------------------------
// hclk_gen : registered, glitch-free HCLK generator with programmable half-period
// Rev 1.0  : optional rise counter enabled by HCLK_CYCLE_CNT_EN
//----------------------------------------------------------------------------
`default_nettype none

module hclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] half_period,
  output logic             HCLK,
  output logic             HCLK_rise,
  output logic             HCLK_fall,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic             r_hclk;
  logic             r_rise;
  logic             r_fall;
  logic             r_running;
  logic [DIV_W-1:0] w_reload;

  // A zero half-period behaves as one, so the reload value is never negative.
  assign w_reload = (half_period == '0) ? '0 : (half_period - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hclk    <= 1'b1;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state   <= LOW;
            r_hclk    <= 1'b0;
            r_fall    <= 1'b1;
            r_cnt     <= w_reload;
            r_running <= 1'b1;
          end
        end
        LOW: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_W'(1);
          end else begin
            r_state <= HIGH;
            r_hclk  <= 1'b1;
            r_rise  <= 1'b1;
            r_cnt   <= w_reload;
          end
        end
        HIGH: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_W'(1);
          end else if (en) begin
            r_state <= LOW;
            r_hclk  <= 1'b0;
            r_fall  <= 1'b1;
            r_cnt   <= w_reload;
          end else begin
            // Park high after a complete high phase; no strobe on stop.
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_hclk    <= 1'b1;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign HCLK      = r_hclk;
  assign HCLK_rise = r_rise;
  assign HCLK_fall = r_fall;
  assign running   = r_running;

`ifdef HCLK_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycle_count;

  // Counts a rise once its strobe cycle has completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if (r_rise) begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hclk_gen.sv
//----------------------------------------------------------------------------
// tb_hclk_gen : randomized bench for hclk_gen against a phase-length model
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_hclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [DIV_W-1:0] half_period = '0;
  logic             HCLK;
  logic             HCLK_rise;
  logic             HCLK_fall;
  logic             running;
  logic [CNT_W-1:0] cycle_count;

  int errors = 0;
  int checks = 0;

  // Model: current level, clk cycles left in the current phase, rises seen so far.
  int m_level  = 1;
  int m_active = 0;
  int m_left   = 0;
  int m_rise   = 0;
  int m_fall   = 0;
  int m_rises  = 0;

  hclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .half_period (half_period),
    .HCLK        (HCLK),
    .HCLK_rise   (HCLK_rise),
    .HCLK_fall   (HCLK_fall),
    .running     (running),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int hp;
    hp = (int'(half_period) == 0) ? 1 : int'(half_period);
    if (m_rise != 0) m_rises++;
    m_rise = 0;
    m_fall = 0;
    if (rst) begin
      m_level = 1; m_active = 0; m_left = 0; m_rises = 0;
    end else if (m_active == 0) begin
      if (en) begin
        m_active = 1; m_level = 0; m_left = hp; m_fall = 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_level == 0) begin
          m_level = 1; m_left = hp; m_rise = 1;
        end else if (en) begin
          m_level = 0; m_left = hp; m_fall = 1;
        end else begin
          m_active = 0;
        end
      end
    end
  endtask

  function automatic int exp_count();
`ifdef HCLK_CYCLE_CNT_EN
    return m_rises % (1 << CNT_W);
`else
    return 0;
`endif
  endfunction

  // One clk cycle: advance the model at the edge, compare all outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("hclk",    int'(HCLK),        m_level);
    check("rise",    int'(HCLK_rise),   m_rise);
    check("fall",    int'(HCLK_fall),   m_fall);
    check("running", int'(running),     m_active);
    check("count",   int'(cycle_count), exp_count());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pat [8];
    int seen;
    int budget;

    // Reset state against fixed values
    do_reset();
    check("rst_hclk",    int'(HCLK),        1);
    check("rst_rise",    int'(HCLK_rise),   0);
    check("rst_fall",    int'(HCLK_fall),   0);
    check("rst_running", int'(running),     0);
    check("rst_count",   int'(cycle_count), 0);

    // hp=2 waveform: 1,0,0,1,1,0,0,1
    pat = '{1, 0, 0, 1, 1, 0, 0, 1};
    en = 1'b1; half_period = 8'd2;
    check("hp2_wave0", int'(HCLK), pat[0]);
    for (int i = 1; i < 8; i++) begin
      step();
      check("hp2_wave", int'(HCLK), pat[i]);
    end

    // hp=0 behaves as 1: toggles every clk
    half_period = 8'd0;
    repeat (12) step();

    // hp=3, drop en on first LOW cycle: full low and high phases, then park
    en = 1'b0;
    repeat (8) step();
    do_reset();
    en = 1'b1; half_period = 8'd3;
    step();
    check("stop_fall", int'(HCLK_fall), 1);
    en = 1'b0;
    repeat (10) step();
    check("stop_hclk", int'(HCLK), 1);
    check("stop_running", int'(running), 0);

    // hp=4 changed to 1 mid-LOW
    en = 1'b1; half_period = 8'd4;
    step();
    step();
    half_period = 8'd1;
    repeat (12) step();

    // Reset on 2nd cycle of a hp=5 low phase, en held high
    en = 1'b0;
    repeat (12) step();
    en = 1'b1; half_period = 8'd5;
    step();
    step();
    rst = 1'b1;
    step();
    check("mid_rst_hclk", int'(HCLK), 1);
    check("mid_rst_rise", int'(HCLK_rise), 0);
    check("mid_rst_running", int'(running), 0);
    rst = 1'b0;
    step();
    check("restart_fall", int'(HCLK_fall), 1);
    repeat (15) step();

    // 17 rises at hp=1, then stop
    do_reset();
    en = 1'b1; half_period = 8'd1;
    seen = 0; budget = 0;
    while (seen < 17 && budget < 200) begin
      step();
      if (HCLK_rise) seen++;
      budget++;
    end
    check("rise_budget", seen, 17);
    en = 1'b0;
    repeat (6) step();
`ifdef HCLK_CYCLE_CNT_EN
    check("wrap_count", int'(cycle_count), 1);
`else
    check("wrap_count", int'(cycle_count), 0);
`endif

    // Randomized enable, half-period and occasional reset
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) half_period = DIV_W'($urandom_range(0, 6));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
